// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the multicycle control path.
// Holds opcode/funct/ALU-op encodings, FSM state and instruction-class enums,
// datapath mux-select encodings and the decoded-control payload struct.
package cpu_types_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUOP_W  = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [FUNCT_W-1:0] {
    FN_SLLV = 6'h04,
    FN_SRLV = 6'h06,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  // ALU_SLL is zero so an idle control word is all-zero.
  typedef enum logic [ALUOP_W-1:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } mc_state_t;

  typedef enum logic [3:0] {
    RTYPE_ALU = 4'd0,
    ITYPE_ALU = 4'd1,
    LOAD      = 4'd2,
    STORE     = 4'd3,
    BRANCH_EQ = 4'd4,
    BRANCH_NE = 4'd5,
    JUMP      = 4'd6,
    JUMP_LINK = 4'd7,
    JUMP_REG  = 4'd8,
    HALT      = 4'd9,
    ILLEGAL   = 4'd10
  } instr_class_t;

  // ExtOp
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;
  // RegDst
  localparam logic [1:0] RD_RD  = 2'd0;
  localparam logic [1:0] RD_RT  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;
  // MemToReg
  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;
  // PCsrc
  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  typedef struct packed {
    instr_class_t cls;
    aluop_t       aluop;
    logic [1:0]   ext_op;
    logic         alu_src;
    logic [1:0]   reg_dst;
    logic [1:0]   mem_to_reg;
    logic         ovf_chk;
  } mc_ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder for the multicycle control unit.
// Ports: i_op (opcode), i_funct (R-type funct) -> o_dec (class plus ALU op,
// extension mode, ALU source, write-back selects and overflow-check flag).
module mc_decode
  import cpu_types_pkg::*;
(
  input  opcode_t  i_op,
  input  funct_t   i_funct,
  output mc_ctrl_t o_dec
);

  always_comb begin
    o_dec            = '0;
    o_dec.cls        = ILLEGAL;
    o_dec.aluop      = ALU_SLL;
    o_dec.ext_op     = EXT_ZERO;
    o_dec.reg_dst    = RD_RD;
    o_dec.mem_to_reg = MTR_ALU;
    case (i_op)
      OP_RTYPE: begin
        o_dec.cls = RTYPE_ALU;
        case (i_funct)
          FN_ADD:  begin o_dec.aluop = ALU_ADD; o_dec.ovf_chk = 1'b1; end
          FN_ADDU: o_dec.aluop = ALU_ADD;
          FN_SUB:  begin o_dec.aluop = ALU_SUB; o_dec.ovf_chk = 1'b1; end
          FN_SUBU: o_dec.aluop = ALU_SUB;
          FN_AND:  o_dec.aluop = ALU_AND;
          FN_OR:   o_dec.aluop = ALU_OR;
          FN_XOR:  o_dec.aluop = ALU_XOR;
          FN_NOR:  o_dec.aluop = ALU_NOR;
          FN_SLT:  o_dec.aluop = ALU_SLT;
          FN_SLTU: o_dec.aluop = ALU_SLTU;
          FN_SLLV: o_dec.aluop = ALU_SLL;
          FN_SRLV: o_dec.aluop = ALU_SRL;
          FN_JR:   o_dec.cls   = JUMP_REG;
          default: o_dec.cls   = ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        o_dec.cls     = ITYPE_ALU;
        o_dec.alu_src = 1'b1;
        o_dec.reg_dst = RD_RT;
        o_dec.ext_op  = EXT_SIGN;
        case (i_op)
          OP_ADDI:  begin o_dec.aluop = ALU_ADD; o_dec.ovf_chk = 1'b1; end
          OP_ADDIU: o_dec.aluop = ALU_ADD;
          OP_SLTI:  o_dec.aluop = ALU_SLT;
          OP_SLTIU: o_dec.aluop = ALU_SLTU;
          OP_ANDI:  begin o_dec.aluop = ALU_AND; o_dec.ext_op = EXT_ZERO; end
          OP_ORI:   begin o_dec.aluop = ALU_OR;  o_dec.ext_op = EXT_ZERO; end
          OP_XORI:  begin o_dec.aluop = ALU_XOR; o_dec.ext_op = EXT_ZERO; end
          default:  begin o_dec.aluop = ALU_OR;  o_dec.ext_op = EXT_LUI;  end
        endcase
      end
      OP_LW: begin
        o_dec.cls        = LOAD;
        o_dec.aluop      = ALU_ADD;
        o_dec.alu_src    = 1'b1;
        o_dec.ext_op     = EXT_SIGN;
        o_dec.reg_dst    = RD_RT;
        o_dec.mem_to_reg = MTR_MEM;
      end
      OP_SW: begin
        o_dec.cls     = STORE;
        o_dec.aluop   = ALU_ADD;
        o_dec.alu_src = 1'b1;
        o_dec.ext_op  = EXT_SIGN;
      end
      OP_BEQ, OP_BNE: begin
        o_dec.cls    = (i_op == OP_BEQ) ? BRANCH_EQ : BRANCH_NE;
        o_dec.aluop  = ALU_SUB;
        o_dec.ext_op = EXT_SIGN;
      end
      OP_J:    o_dec.cls = JUMP;
      OP_JAL: begin
        o_dec.cls        = JUMP_LINK;
        o_dec.reg_dst    = RD_R31;
        o_dec.mem_to_reg = MTR_PC;
      end
      OP_HALT: o_dec.cls = HALT;
      default: o_dec.cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer that waits
// on ihit/dhit and emits per-state datapath strobes and mux selects.
// Inputs : CLK, RST (sync, active-high), instr, ihit, dhit, zero, overflow.
// Outputs: iREN/dREN/dWEN memory requests, irWEN/pcWEN/regWEN write enables,
//          RegDst/ALUsrc/ExtOp/MemToReg/PCsrc selects, aluop, sticky halt, state.
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter bit          OVF_TRAP = 1'b1,
  parameter int unsigned WORD_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] instr,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  input  logic              overflow,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              irWEN,
  output logic              pcWEN,
  output logic              regWEN,
  output logic [1:0]        RegDst,
  output logic              ALUsrc,
  output logic [1:0]        ExtOp,
  output logic [1:0]        MemToReg,
  output logic [1:0]        PCsrc,
  output aluop_t            aluop,
  output logic              halt,
  output mc_state_t         state
);

  localparam int unsigned OP_LSB = 26;

  mc_state_t r_state;
  mc_state_t w_next;
  mc_state_t w_state;
  opcode_t   r_op;
  funct_t    r_funct;
  mc_ctrl_t  r_dec;
  mc_ctrl_t  w_dec;
  logic      r_ovf_q;
  logic      w_ihit;
  logic      w_trap;
  logic      w_unused;

  // Only the opcode and funct fields steer control.
  assign w_unused = ^instr;

  mc_decode u_decode (
    .i_op   (r_op),
    .i_funct(r_funct),
    .o_dec  (w_dec)
  );

  // While RST is high the outputs look like an idle FETCH, so no write
  // strobe from the interrupted state can leak into the reset cycle.
  assign w_state = RST ? FETCH : r_state;
  assign w_ihit  = ihit & ~RST;
  assign w_trap  = OVF_TRAP & r_dec.ovf_chk & r_ovf_q;
  assign state   = w_state;

  // State, fetched fields, decoded class and overflow sample
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FETCH;
      r_op    <= OP_RTYPE;
      r_funct <= FN_ADD;
      r_dec   <= '0;
      r_ovf_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && ihit) begin
        r_op    <= opcode_t'(instr[OP_LSB +: OPCODE_W]);
        r_funct <= funct_t'(instr[FUNCT_W-1:0]);
      end
      if (r_state == DECODE) r_dec   <= w_dec;
      if (r_state == EXEC)   r_ovf_q <= overflow;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    w_next   = r_state;
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    irWEN    = 1'b0;
    pcWEN    = 1'b0;
    regWEN   = 1'b0;
    RegDst   = RD_RD;
    ALUsrc   = 1'b0;
    ExtOp    = EXT_ZERO;
    MemToReg = MTR_ALU;
    PCsrc    = PC_NEXT;
    aluop    = ALU_SLL;
    halt     = 1'b0;
    case (w_state)
      FETCH: begin
        iREN = 1'b1;
        if (w_ihit) begin
          irWEN  = 1'b1;
          pcWEN  = 1'b1;
          PCsrc  = PC_NEXT;
          w_next = DECODE;
        end
      end
      DECODE: w_next = EXEC;
      EXEC: begin
        aluop  = r_dec.aluop;
        ALUsrc = r_dec.alu_src;
        ExtOp  = r_dec.ext_op;
        w_next = FETCH;
        case (r_dec.cls)
          RTYPE_ALU, ITYPE_ALU: w_next = WB;
          LOAD, STORE:          w_next = MEM;
          BRANCH_EQ: begin PCsrc = PC_BRANCH; pcWEN = zero;  end
          BRANCH_NE: begin PCsrc = PC_BRANCH; pcWEN = ~zero; end
          JUMP:      begin PCsrc = PC_JUMP;   pcWEN = 1'b1;  end
          JUMP_REG:  begin PCsrc = PC_RS;     pcWEN = 1'b1;  end
          JUMP_LINK: begin
            PCsrc    = PC_JUMP;
            pcWEN    = 1'b1;
            regWEN   = 1'b1;
            RegDst   = r_dec.reg_dst;
            MemToReg = r_dec.mem_to_reg;
          end
          HALT:    w_next = HALTED;
          default: w_next = FETCH;
        endcase
      end
      MEM: begin
        aluop  = r_dec.aluop;
        ALUsrc = r_dec.alu_src;
        ExtOp  = r_dec.ext_op;
        if (r_dec.cls == LOAD) begin
          dREN = 1'b1;
          if (dhit) w_next = WB;
        end else if (r_dec.cls == STORE) begin
          dWEN = 1'b1;
          if (dhit) w_next = FETCH;
        end else begin
          w_next = FETCH;
        end
      end
      WB: begin
        aluop    = r_dec.aluop;
        ALUsrc   = r_dec.alu_src;
        ExtOp    = r_dec.ext_op;
        RegDst   = r_dec.reg_dst;
        MemToReg = r_dec.mem_to_reg;
        if (w_trap) begin
          w_next = HALTED;
        end else begin
          regWEN = 1'b1;
          w_next = FETCH;
        end
      end
      HALTED: begin
        halt   = 1'b1;
        w_next = HALTED;
      end
      default: w_next = FETCH;
    endcase
  end

endmodule
